// File: rtl/clint_rtc_gen.sv
// RTC square-wave generator feeding the CLINT timebase, programmed through a small valid/ready register port.
// Optional build macro CLINT_RTC_HALT_SYNC_EN: route halt_i through a 2-flop synchronizer before use.
module clint_rtc_gen #(
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd24,
    parameter logic                 DEFAULT_EN  = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    input  logic        halt_i,
    output logic        rtc_o,
    output logic        running_o
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_TICKS  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [31:0]          ticks_q;
    logic                 rtc_q;
    logic                 running_q;
    logic                 en_q;
    logic                 frz_q;
    logic                 halted_q;
    logic                 ready_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;

    logic                 halt_eff_s;
    logic                 accept_s;
    logic                 wr_ctrl_s;
    logic                 wr_div_s;
    logic                 wr_ticks_s;
    logic                 wr_status_s;
    logic [DIV_WIDTH-1:0] div_wr_s;
    logic [31:0]          rdata_d;
    logic                 freeze_s;
    logic                 reload_s;
    logic                 rise_s;
    logic                 unused_wdata_s;

    assign unused_wdata_s = ^cfg_wdata_i[31:DIV_WIDTH];

`ifdef CLINT_RTC_HALT_SYNC_EN
    logic [1:0] halt_sync_q;

    // Two-stage synchronizer for the asynchronous debug halt request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            halt_sync_q <= 2'b00;
        end else begin
            halt_sync_q <= {halt_sync_q[0], halt_i};
        end
    end

    assign halt_eff_s = halt_sync_q[1];
`else
    assign halt_eff_s = halt_i;
`endif

    // Request decode and read-data selection; reads see register values from before this cycle's edge.
    always_comb begin
        accept_s    = cfg_valid_i & ready_q;
        wr_ctrl_s   = 1'b0;
        wr_div_s    = 1'b0;
        wr_ticks_s  = 1'b0;
        wr_status_s = 1'b0;
        rdata_d     = 32'd0;
        div_wr_s    = cfg_wdata_i[DIV_WIDTH-1:0];
        if (div_wr_s == DIV_ZERO) begin
            div_wr_s = DIV_ONE;
        end else begin
            div_wr_s = cfg_wdata_i[DIV_WIDTH-1:0];
        end
        if (accept_s && cfg_we_i) begin
            case (cfg_addr_i)
                ADDR_CTRL:   wr_ctrl_s   = 1'b1;
                ADDR_DIV:    wr_div_s    = 1'b1;
                ADDR_TICKS:  wr_ticks_s  = 1'b1;
                ADDR_STATUS: wr_status_s = 1'b1;
                default:     wr_status_s = 1'b0;
            endcase
        end else if (accept_s) begin
            case (cfg_addr_i)
                ADDR_CTRL:   rdata_d = {30'd0, frz_q, en_q};
                ADDR_DIV:    rdata_d = {{(32-DIV_WIDTH){1'b0}}, div_q};
                ADDR_TICKS:  rdata_d = ticks_q;
                ADDR_STATUS: rdata_d = {30'd0, halted_q, running_q};
                default:     rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Config registers and the one-cycle response slot that also blocks back-to-back accepts.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            en_q     <= DEFAULT_EN;
            frz_q    <= 1'b1;
            div_q    <= DEFAULT_DIV;
            halted_q <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            ready_q  <= ~accept_s;
            rvalid_q <= accept_s;
            rdata_q  <= rdata_d;
            if (wr_ctrl_s) begin
                en_q  <= cfg_wdata_i[0];
                frz_q <= cfg_wdata_i[1];
            end
            if (wr_div_s) begin
                div_q <= div_wr_s;
            end
            // A halt in the same cycle as the clear keeps the sticky bit set.
            if (halt_eff_s) begin
                halted_q <= 1'b1;
            end else if (wr_status_s && cfg_wdata_i[1]) begin
                halted_q <= 1'b0;
            end
        end
    end

    // Toggle and rising-edge qualification for the running half-period counter.
    always_comb begin
        freeze_s = halt_eff_s & frz_q;
        reload_s = (cnt_q == DIV_ZERO);
        if ((state_q == ST_RUN) && en_q && !freeze_s && reload_s && !rtc_q) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
    end

    // Generator FSM: divider countdown, rtc level, run indication and tick count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= DIV_ZERO;
            rtc_q     <= 1'b0;
            running_q <= 1'b0;
            ticks_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= div_q;
                        running_q <= 1'b1;
                    end else begin
                        cnt_q     <= DIV_ZERO;
                        running_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!en_q) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= DIV_ZERO;
                        running_q <= 1'b0;
                    end else if (freeze_s) begin
                        state_q   <= ST_FROZEN;
                        running_q <= 1'b0;
                    end else if (reload_s) begin
                        rtc_q     <= ~rtc_q;
                        cnt_q     <= div_q;
                        running_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q - DIV_ONE;
                        running_q <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (!en_q) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= DIV_ZERO;
                        running_q <= 1'b0;
                    end else if (!halt_eff_s) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= DIV_ZERO;
                    running_q <= 1'b0;
                end
            endcase
            // Software clear outranks a coincident rising edge.
            if (wr_ticks_s) begin
                ticks_q <= 32'd0;
            end else if (rise_s) begin
                ticks_q <= ticks_q + 32'd1;
            end
        end
    end

    assign cfg_ready_o  = ready_q;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign rtc_o        = rtc_q;
    assign running_o    = running_q;

    clint_rtc_gen_chk u_chk (
        .clk_i        (aclk),
        .rst_i        (areset),
        .cfg_ready_i  (ready_q),
        .cfg_rvalid_i (rvalid_q),
        .rtc_i        (rtc_q),
        .running_i    (running_q)
    );

endmodule

// Protocol and output-stability properties for clint_rtc_gen.
module clint_rtc_gen_chk (
    input logic clk_i,
    input logic rst_i,
    input logic cfg_ready_i,
    input logic cfg_rvalid_i,
    input logic rtc_i,
    input logic running_i
);

    a_resp_blocks_accept: assert property (@(posedge clk_i) disable iff (rst_i)
        cfg_rvalid_i |-> !cfg_ready_i);

    // The RTC level can only move on a cycle that started in RUN.
    a_rtc_static_when_stopped: assert property (@(posedge clk_i) disable iff (rst_i)
        !running_i |=> $stable(rtc_i));

endmodule
